// File: rtl/qspi_fill_arbiter_if.sv
// Bundle of request, response and QSPI-controller signals for qspi_fill_arbiter.
//   master : arbiter side (drives req_ack, rsp_*, busy, qspi_start_read, qspi_addr)
//   slave  : requesters + controller side (drives req, req_addr, qspi_rready,
//            qspi_rvalid, qspi_rdata)
// Parameters must match those of the qspi_fill_arbiter instance using it.
interface qspi_fill_arbiter_if #(
  parameter int ADDR_W     = 24,
  parameter int LINE_WORDS = 4,
  parameter int NUM_REQ    = 2
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [BEAT_W-1:0]         rsp_beat;
  logic                      rsp_last;
  logic [31:0]               rsp_data;
  logic                      busy;
  logic                      qspi_rready;
  logic                      qspi_start_read;
  logic [ADDR_W-1:0]         qspi_addr;
  logic                      qspi_rvalid;
  logic [31:0]               qspi_rdata;

  modport master (
    input  req, req_addr, qspi_rready, qspi_rvalid, qspi_rdata,
    output req_ack, rsp_valid, rsp_id, rsp_beat, rsp_last, rsp_data, busy,
           qspi_start_read, qspi_addr
  );

  modport slave (
    output req, req_addr, qspi_rready, qspi_rvalid, qspi_rdata,
    input  req_ack, rsp_valid, rsp_id, rsp_beat, rsp_last, rsp_data, busy,
           qspi_start_read, qspi_addr
  );
endinterface

// File: rtl/qspi_fill_arbiter.sv
// Round-robin arbiter and line-fill sequencer in front of the QSPI read controller.
// Grants one of NUM_REQ requesters, issues LINE_WORDS sequential 32-bit reads from
// the line base, and returns each word tagged with requester id, beat and last flag.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : qspi_fill_arbiter_if.master (requests, responses, controller handshake)
module qspi_fill_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int LINE_WORDS = 4,
  parameter int NUM_REQ    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  qspi_fill_arbiter_if.master bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     prio;
  logic [ID_W-1:0]     id;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   addr_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [BEAT_W-1:0]   rsp_beat_q;
  logic                rsp_last_q;
  logic [31:0]         rsp_data_q;

  logic                found;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     grant_id;
  logic [NUM_REQ-1:0]  ack;
  logic                start_read;
  logic                last_beat;
  logic [ADDR_W-1:0]   grant_base;

  assign last_beat  = (beat == LAST_BEAT);
  assign grant_base = bus.req_addr[grant_id*ADDR_W +: ADDR_W] & ~LINE_MASK;

  always_comb begin
    state_next = state;
    found      = 1'b0;
    cand       = '0;
    grant_id   = '0;
    ack        = '0;
    start_read = 1'b0;
    // First requester at or above prio, wrapping modulo NUM_REQ.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(prio) + i) % 32'(NUM_REQ));
      if (!found && bus.req[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    case (state)
      IDLE: begin
        if (found) begin
          ack[grant_id] = rst_n;  // no grant may be seen while reset is asserted
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        start_read = bus.qspi_rready;
        if (bus.qspi_rready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.qspi_rvalid) state_next = last_beat ? IDLE : ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= '0;
      id          <= '0;
      beat        <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_beat_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_next;
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            id     <= grant_id;
            beat   <= '0;
            addr_q <= grant_base;
          end
        end
        WAIT: begin
          if (bus.qspi_rvalid) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.qspi_rdata;
            rsp_id_q    <= id;
            rsp_beat_q  <= beat;
            rsp_last_q  <= last_beat;
            if (last_beat) begin
              prio <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
            end else begin
              beat   <= beat + 1'b1;
              addr_q <= addr_q + ADDR_W'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ack         = ack;
  assign bus.qspi_start_read = start_read;
  assign bus.qspi_addr       = addr_q;
  assign bus.busy            = (state != IDLE);
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_beat        = rsp_beat_q;
  assign bus.rsp_last        = rsp_last_q;
  assign bus.rsp_data        = rsp_data_q;
endmodule

// File: tb/tb_qspi_fill_arbiter.sv
// Directed bench for qspi_fill_arbiter (ADDR_W=24, LINE_WORDS=4, NUM_REQ=2).
// A table of fill records is replayed through a small controller model; the
// rready stall, spurious rvalid and mid-fill reset cases are hand sequenced.
module tb_qspi_fill_arbiter;
  logic clk;
  logic rst_n;
  int unsigned n_tests;
  int unsigned n_fail;

  qspi_fill_arbiter_if #(.ADDR_W(24), .LINE_WORDS(4), .NUM_REQ(2)) bus ();

  qspi_fill_arbiter #(.ADDR_W(24), .LINE_WORDS(4), .NUM_REQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req_set;
    logic [23:0] a0;
    logic [23:0] a1;
    int unsigned exp_id;
    logic [23:0] exp_base;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return {8'hA5, a};
  endfunction

  // Starts at a negedge with the DUT in ISSUE; ends at the negedge after the
  // response for beat nbeats-1 (IDLE there when nbeats covers the whole line).
  task automatic run_beats(input int unsigned exp_id, input logic [23:0] base,
                           input int unsigned nbeats);
    logic [23:0] a;
    for (int unsigned k = 0; k < nbeats; k++) begin
      a = base + 24'(4 * k);
      bus.qspi_rready = 1'b1;
      #1;
      check($sformatf("start_read b%0d", k), 32'(bus.qspi_start_read), 32'd1);
      check($sformatf("qspi_addr b%0d", k), 32'(bus.qspi_addr), 32'(a));
      check($sformatf("ack_busy b%0d", k), 32'(bus.req_ack), 32'd0);
      check($sformatf("busy b%0d", k), 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.qspi_rvalid = 1'b1;
      bus.qspi_rdata  = word_at(a);
      #1;
      check($sformatf("start_wait b%0d", k), 32'(bus.qspi_start_read), 32'd0);
      check($sformatf("addr_hold b%0d", k), 32'(bus.qspi_addr), 32'(a));
      @(negedge clk);
      bus.qspi_rvalid = 1'b0;
      #1;
      check($sformatf("rsp_valid b%0d", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("rsp_data b%0d", k), bus.rsp_data, word_at(a));
      check($sformatf("rsp_id b%0d", k), 32'(bus.rsp_id), exp_id);
      check($sformatf("rsp_beat b%0d", k), 32'(bus.rsp_beat), k);
      check($sformatf("rsp_last b%0d", k), 32'(bus.rsp_last), (k == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Pairs: loser keeps req and wins next; prio returns to 0 after id 1.
    vecs[0] = '{2'b11, 24'h000104, 24'h000208, 0, 24'h000100};
    vecs[1] = '{2'b00, 24'h000104, 24'h000208, 1, 24'h000200};
    vecs[2] = '{2'b11, 24'h00031C, 24'h00042F, 0, 24'h000310};
    vecs[3] = '{2'b00, 24'h00031C, 24'h00042F, 1, 24'h000420};
    vecs[4] = '{2'b01, 24'h000013, 24'h000000, 0, 24'h000010};
    vecs[5] = '{2'b01, 24'h12345A, 24'h000000, 0, 24'h123450};  // prio 1, wraps to 0
    vecs[6] = '{2'b10, 24'h000000, 24'hFFFFFC, 1, 24'hFFFFF0};  // top line
    vecs[7] = '{2'b10, 24'h000000, 24'h00001F, 1, 24'h000010};  // prio 0, scans to 1

    rst_n = 1'b0;
    bus.req = 2'b01;
    bus.req_addr = {24'h0, 24'h000040};
    bus.qspi_rready = 1'b0;
    bus.qspi_rvalid = 1'b0;
    bus.qspi_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst ack", 32'(bus.req_ack), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst qspi_addr", 32'(bus.qspi_addr), 32'd0);
    @(negedge clk);
    bus.req = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    for (int unsigned v = 0; v < 8; v++) begin
      bus.req = bus.req | vecs[v].req_set;
      bus.req_addr = {vecs[v].a1, vecs[v].a0};
      #1;
      check($sformatf("v%0d ack", v), 32'(bus.req_ack), 32'd1 << vecs[v].exp_id);
      check($sformatf("v%0d idle", v), 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.req[vecs[v].exp_id] = 1'b0;
      run_beats(vecs[v].exp_id, vecs[v].exp_base, 4);
    end

    // Spurious rvalid in IDLE.
    bus.qspi_rvalid = 1'b1;
    @(negedge clk);
    bus.qspi_rvalid = 1'b0;
    #1;
    check("idle rvalid rsp", 32'(bus.rsp_valid), 32'd0);
    check("idle rvalid busy", 32'(bus.busy), 32'd0);

    // rready low for 10 cycles in ISSUE, with spurious rvalid pulses.
    bus.req = 2'b01;
    bus.req_addr = {24'h0, 24'h000040};
    bus.qspi_rready = 1'b0;
    #1;
    check("stall ack", 32'(bus.req_ack), 32'd1);
    @(negedge clk);
    bus.req = 2'b00;
    for (int unsigned c = 0; c < 10; c++) begin
      #1;
      check($sformatf("stall start c%0d", c), 32'(bus.qspi_start_read), 32'd0);
      check($sformatf("stall addr c%0d", c), 32'(bus.qspi_addr), 32'h40);
      check($sformatf("stall rsp c%0d", c), 32'(bus.rsp_valid), 32'd0);
      check($sformatf("stall busy c%0d", c), 32'(bus.busy), 32'd1);
      bus.qspi_rvalid = c[0];
      @(negedge clk);
    end
    bus.qspi_rvalid = 1'b0;
    #1;
    check("stall rsp end", 32'(bus.rsp_valid), 32'd0);
    run_beats(0, 24'h000040, 4);

    // Reset while waiting on beat 2, then a clean fill for requester 1.
    bus.req = 2'b01;
    bus.req_addr = {24'h0, 24'h000200};
    #1;
    check("r5 ack", 32'(bus.req_ack), 32'd1);
    @(negedge clk);
    bus.req = 2'b00;
    run_beats(0, 24'h000200, 2);
    bus.qspi_rready = 1'b1;
    #1;
    check("r5 start b2", 32'(bus.qspi_start_read), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 2'b10;
    bus.req_addr = {24'h000345, 24'h0};
    bus.qspi_rvalid = 1'b1;
    bus.qspi_rdata = 32'hDEADBEEF;
    #1;
    check("r5 ack0", 32'(bus.req_ack), 32'd0);
    check("r5 rsp_valid0", 32'(bus.rsp_valid), 32'd0);
    check("r5 rsp_id0", 32'(bus.rsp_id), 32'd0);
    check("r5 rsp_beat0", 32'(bus.rsp_beat), 32'd0);
    check("r5 rsp_last0", 32'(bus.rsp_last), 32'd0);
    check("r5 rsp_data0", bus.rsp_data, 32'd0);
    check("r5 busy0", 32'(bus.busy), 32'd0);
    check("r5 start0", 32'(bus.qspi_start_read), 32'd0);
    check("r5 addr0", 32'(bus.qspi_addr), 32'd0);
    @(negedge clk);
    bus.qspi_rvalid = 1'b0;
    #1;
    check("r5 rsp_valid held", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("r5 ack1", 32'(bus.req_ack), 32'd2);
    @(negedge clk);
    bus.req = 2'b00;
    run_beats(1, 24'h000340, 4);
    @(negedge clk);
    #1;
    check("final idle", 32'(bus.busy), 32'd0);
    check("final rsp_valid", 32'(bus.rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
